// File: rtl/gate_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gate_alu_pipe
// Purpose  : Two-stage valid/ready pipeline applying one of eight bitwise
//            logic operations to WIDTH-bit operands. It produces zero, ones
//            and parity flags. In accumulate mode the previous result is
//            chained in as operand A.
// Ports    : clk, rst_n (async, active low), flush (sync clear)
//            in_valid/in_ready/in_op/in_acc/in_a/in_b : command side
//            out_valid/out_ready/out_result/out_zero/out_ones/out_parity
//                                                     : result side
// Revision : 1.0 - initial release
// ============================================================================
module gate_alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    localparam logic [2:0] c_op_not_a = 3'd0;
    localparam logic [2:0] c_op_not_b = 3'd1;
    localparam logic [2:0] c_op_and   = 3'd2;
    localparam logic [2:0] c_op_or    = 3'd3;
    localparam logic [2:0] c_op_xor   = 3'd4;
    localparam logic [2:0] c_op_nand  = 3'd5;
    localparam logic [2:0] c_op_nor   = 3'd6;
    localparam logic [2:0] c_op_xnor  = 3'd7;

    // Stage 1: captured command
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic             r_s1_acc;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // Stage 2: result register (also the accumulator) and its flags
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ones;
    logic             r_parity;

    logic             w_ready_s2;
    logic             w_accept;
    logic             w_load_s2;
    logic             w_drain;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_res;

    // Combinational ready chain. Flush forces in_ready low, which also
    // drops any command presented in the flush cycle.
    assign w_ready_s2 = !r_s2_valid || out_ready;
    assign in_ready   = !flush && (!r_s1_valid || w_ready_s2);
    assign w_accept   = in_valid && in_ready;
    assign w_load_s2  = !flush && r_s1_valid && w_ready_s2;
    assign w_drain    = r_s2_valid && out_ready;

    // Operand A comes from the result register when accumulating. Because
    // the computation happens at stage-2 load, the value used is always the
    // result of the immediately preceding command, so back-to-back
    // accumulates chain without a bubble.
    assign w_opa = r_s1_acc ? r_result : r_s1_a;

    always_comb begin
        w_res = '0;
        case (r_s1_op)
            c_op_not_a: w_res = ~w_opa;
            c_op_not_b: w_res = ~r_s1_b;
            c_op_and:   w_res = w_opa & r_s1_b;
            c_op_or:    w_res = w_opa | r_s1_b;
            c_op_xor:   w_res = w_opa ^ r_s1_b;
            c_op_nand:  w_res = ~(w_opa & r_s1_b);
            c_op_nor:   w_res = ~(w_opa | r_s1_b);
            c_op_xnor:  w_res = ~(w_opa ^ r_s1_b);
            default:    w_res = '0;
        endcase
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 3'd0;
            r_s1_acc   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= in_op;
                r_s1_acc   <= in_acc;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
            end else if (w_load_s2) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 register. The flags are registered with the result so they
    // always describe the value currently being presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_ones     <= 1'b0;
            r_parity   <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_ones     <= 1'b0;
            r_parity   <= 1'b0;
        end else if (w_load_s2) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_res;
            r_zero     <= ~|w_res;
            r_ones     <= &w_res;
            r_parity   <= ^w_res;
        end else if (w_drain) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_ones   = r_ones;
    assign out_parity = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_gate_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_alu_pipe
// Purpose  : Directed self-checking bench for gate_alu_pipe. It uses a
//            WIDTH=8 instance for the main scenarios and a WIDTH=1 instance
//            for the single-bit truth-table sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       flush;

    // WIDTH=8 instance signals
    logic       in_valid, in_ready, in_acc, out_valid, out_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b, out_result;
    logic       out_zero, out_ones, out_parity;

    // WIDTH=1 instance signals
    logic       in_valid1, in_ready1, in_acc1, out_valid1, out_ready1;
    logic [2:0] in_op1;
    logic [0:0] in_a1, in_b1, out_result1;
    logic       out_zero1, out_ones1, out_parity1;

    int n_checks = 0;
    int n_errors = 0;

    // Truth tables indexed by {a,b}
    logic [3:0] tt [8];
    logic [2:0] opj;
    logic [1:0] abj;

    gate_alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_acc(in_acc), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity)
    );

    gate_alu_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1),
        .in_acc(in_acc1), .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1),
        .out_zero(out_zero1), .out_ones(out_ones1), .out_parity(out_parity1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic v, input logic [2:0] op, input logic acc,
                       input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_op    = op;
        in_acc   = acc;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic res(input string tag, input logic [7:0] r, input logic z,
                       input logic o, input logic p);
        chk({tag, "_valid"},  out_valid, 1'b1);
        chk({tag, "_result"}, out_result, r);
        chk({tag, "_zero"},   out_zero, z);
        chk({tag, "_ones"},   out_ones, o);
        chk({tag, "_parity"}, out_parity, p);
    endtask

    initial begin
        tt[0] = 4'b0011; tt[1] = 4'b0101; tt[2] = 4'b1000; tt[3] = 4'b1110;
        tt[4] = 4'b0110; tt[5] = 4'b0111; tt[6] = 4'b0001; tt[7] = 4'b1001;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; out_ready1 = 1'b1;
        cmd(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
        in_valid1 = 1'b0; in_op1 = 3'd0; in_acc1 = 1'b0; in_a1 = 1'b0; in_b1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        // ---------------- reset state ----------------
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", out_result, 8'h00);
        chk("rst_zero", out_zero, 1'b1);
        chk("rst_ones", out_ones, 1'b0);
        chk("rst_parity", out_parity, 1'b0);
        chk("rst_w1_valid", out_valid1, 1'b0);

        // ---------------- accumulate chain ----------------
        @(negedge clk); cmd(1'b1, 3'd4, 1'b1, 8'hEE, 8'h01);
        @(negedge clk); cmd(1'b1, 3'd4, 1'b1, 8'hEE, 8'h02);
        @(negedge clk); cmd(1'b1, 3'd4, 1'b1, 8'hEE, 8'h04); #1;
        res("acc1", 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk); cmd(1'b1, 3'd0, 1'b1, 8'h00, 8'h00); #1;
        res("acc2", 8'h03, 1'b0, 1'b0, 1'b0);
        @(negedge clk); cmd(1'b0, 3'd0, 1'b0, 8'h00, 8'h00); #1;
        res("acc3", 8'h07, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        res("acc_nota", 8'hF8, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        chk("acc_idle_valid", out_valid, 1'b0);

        // ---------------- AND / NOR ----------------
        @(negedge clk); cmd(1'b1, 3'd2, 1'b0, 8'hF0, 8'h3C);
        @(negedge clk); cmd(1'b1, 3'd6, 1'b0, 8'hFF, 8'h00);
        @(negedge clk); cmd(1'b0, 3'd0, 1'b0, 8'h00, 8'h00); #1;
        res("and", 8'h30, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        res("nor", 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        cmd(1'b1, 3'd4, 1'b0, 8'h01, 8'h02); #1;
        chk("bp_ready1", in_ready, 1'b1);
        @(negedge clk); cmd(1'b1, 3'd4, 1'b0, 8'h04, 8'h08); #1;
        chk("bp_ready2", in_ready, 1'b1);
        @(negedge clk); cmd(1'b1, 3'd4, 1'b0, 8'h10, 8'h20); #1;
        chk("bp_ready3", in_ready, 1'b0);
        res("bp_hold0", 8'h03, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_op = 3'(k); in_a = 8'hA5; in_b = 8'h5A;   // ignored while stalled
            #1;
            chk("bp_stall_ready", in_ready, 1'b0);
            chk("bp_stall_result", out_result, 8'h03);
            chk("bp_stall_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        cmd(1'b1, 3'd4, 1'b0, 8'h10, 8'h20);
        out_ready = 1'b1; #1;
        chk("bp_release_ready", in_ready, 1'b1);
        res("bp_out1", 8'h03, 1'b0, 1'b0, 1'b0);
        @(negedge clk); cmd(1'b0, 3'd0, 1'b0, 8'h00, 8'h00); #1;
        res("bp_out2", 8'h0C, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        res("bp_out3", 8'h30, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("bp_done_valid", out_valid, 1'b0);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        cmd(1'b1, 3'd3, 1'b0, 8'h0F, 8'hF0);
        @(negedge clk); cmd(1'b1, 3'd2, 1'b0, 8'hFF, 8'hFF);
        @(negedge clk); cmd(1'b1, 3'd4, 1'b0, 8'h11, 8'h22);
        flush = 1'b1; #1;
        chk("fl_pre_result", out_result, 8'hFF);
        chk("fl_in_ready", in_ready, 1'b0);
        @(negedge clk); flush = 1'b0; cmd(1'b0, 3'd0, 1'b0, 8'h00, 8'h00); #1;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_result", out_result, 8'h00);
        chk("fl_zero", out_zero, 1'b1);
        chk("fl_in_ready_after", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("fl_dropped_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        cmd(1'b1, 3'd3, 1'b1, 8'hAA, 8'h55);
        @(negedge clk); cmd(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
        @(negedge clk); #1;
        res("fl_acc_or", 8'h55, 1'b0, 1'b0, 1'b0);

        // ---------------- async reset ----------------
        @(negedge clk);
        out_ready = 1'b0;
        cmd(1'b1, 3'd4, 1'b0, 8'hAA, 8'h00);
        @(negedge clk); cmd(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
        @(negedge clk); #1;
        res("ar_stalled", 8'hAA, 1'b0, 1'b0, 1'b0);
        #1; rst_n = 1'b0; #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_result", out_result, 8'h00);
        chk("ar_zero", out_zero, 1'b1);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("ar_in_ready", in_ready, 1'b1);
        @(negedge clk); #1;
        chk("ar_no_result", out_valid, 1'b0);
        out_ready = 1'b1;

        // ---------------- WIDTH=1 exhaustive sweep ----------------
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (i < 32) begin
                in_valid1 = 1'b1;
                in_op1    = i[4:2];
                in_a1     = i[1];
                in_b1     = i[0];
            end else begin
                in_valid1 = 1'b0;
            end
            #1;
            if (i >= 2) begin
                opj = 3'((i - 2) >> 2);
                abj = 2'((i - 2) & 3);
                chk($sformatf("w1_valid_op%0d_ab%0d", opj, abj), out_valid1, 1'b1);
                chk($sformatf("w1_result_op%0d_ab%0d", opj, abj), out_result1, tt[opj][abj]);
            end
        end
        // NAND with a=1, b=0 gives 1
        @(negedge clk);
        in_valid1 = 1'b1; in_op1 = 3'd5; in_a1 = 1'b1; in_b1 = 1'b0;
        @(negedge clk); in_valid1 = 1'b0;
        @(negedge clk); #1;
        chk("w1_nand_10", out_result1, 1'b1);
        chk("w1_nand_10_parity", out_parity1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
